// File: rtl/texture_writer_if.sv
// Peripheral bus bundle between the picosoc bus master and texture_writer.
interface texture_writer_if;
  logic        valid;
  logic [3:0]  wstrb;
  logic [3:0]  addr;
  logic [31:0] wdata;
  logic        ready;
  logic [31:0] rdata;

  modport master (
    output valid, wstrb, addr, wdata,
    input  ready, rdata
  );

  modport slave (
    input  valid, wstrb, addr, wdata,
    output ready, rdata
  );
endinterface

// File: rtl/texture_writer.sv
// CPU-side write controller for the texture memory: register file with an
// auto-incrementing pointer, 8-texel unpack of DATA writes, and a fill engine.
module texture_writer #(
  parameter int ADDR_W = 12
) (
  input  logic              clk,
  input  logic              resetn,
  texture_writer_if.slave   bus,
  output logic              tm_wen,
  output logic [ADDR_W-1:0] tm_waddr,
  output logic [2:0]        tm_wdata
);

  typedef enum logic [1:0] {S_IDLE, S_UNPACK, S_FILL} state_t;

  localparam logic [1:0] REG_PTR    = 2'd0;
  localparam logic [1:0] REG_DATA   = 2'd1;
  localparam logic [1:0] REG_FILL   = 2'd2;
  localparam logic [1:0] REG_STATUS = 2'd3;
  localparam logic [ADDR_W-1:0] PTR_ONE = {{(ADDR_W-1){1'b0}}, 1'b1};

  state_t            state, state_n;
  logic [ADDR_W-1:0] ptr, ptr_n;
  logic [2:0]        idx, idx_n;
  logic [11:0]       rem, rem_n;
  logic [23:0]       texels, texels_n;
  logic [2:0]        color, color_n;
  logic              ready_q, ready_n;
  logic [31:0]       rdata_q, rdata_n;
  logic              wen_n;
  logic [ADDR_W-1:0] waddr_n;
  logic [2:0]        wdat_n;
  logic              req, is_wr, busy;
  logic [1:0]        rsel;
  logic [31:0]       status;
  logic              unused_bits;

  function automatic logic [2:0] texel_at(input logic [23:0] t, input logic [2:0] i);
    logic [4:0] b;
    b = {2'b00, i} * 5'd3;
    return t[b +: 3];
  endfunction

  // A request is new only while our acknowledge is low; held valid after ready is ignored.
  assign req    = bus.valid && !ready_q;
  assign is_wr  = |bus.wstrb;
  assign rsel   = bus.addr[3:2];
  assign busy   = (state != S_IDLE);
  assign bus.ready = ready_q;
  assign bus.rdata = rdata_q;
  assign unused_bits = ^{bus.addr[1:0], bus.wdata[31:24]};

  // STATUS word: busy flag on top, pointer zero-extended below.
  always_comb begin
    status     = 32'(ptr);
    status[31] = busy;
  end

  // Next-state logic: bus acceptance, unpack sequencing and fill countdown.
  always_comb begin
    state_n  = state;
    ptr_n    = ptr;
    idx_n    = idx;
    rem_n    = rem;
    texels_n = texels;
    color_n  = color;
    ready_n  = 1'b0;
    rdata_n  = rdata_q;
    wen_n    = 1'b0;
    waddr_n  = tm_waddr;
    wdat_n   = tm_wdata;

    // Reads are served in any state, so firmware can poll STATUS while busy.
    if (req && !is_wr) begin
      ready_n = 1'b1;
      case (rsel)
        REG_PTR:    rdata_n = 32'(ptr);
        REG_STATUS: rdata_n = status;
        default:    rdata_n = 32'd0;
      endcase
    end

    case (state)
      S_IDLE: begin
        if (req && is_wr) begin
          ready_n = 1'b1;
          rdata_n = 32'd0;
          case (rsel)
            REG_PTR: ptr_n = bus.wdata[ADDR_W-1:0];
            REG_DATA: begin
              // Texel 0 goes out on the acceptance edge; the rest follow back to back.
              texels_n = bus.wdata[23:0];
              wen_n    = 1'b1;
              waddr_n  = ptr;
              wdat_n   = bus.wdata[2:0];
              ptr_n    = ptr + PTR_ONE;
              idx_n    = 3'd1;
              state_n  = S_UNPACK;
            end
            REG_FILL: begin
              // rem holds the texels still to write after this first one.
              color_n = bus.wdata[2:0];
              rem_n   = bus.wdata[15:4];
              wen_n   = 1'b1;
              waddr_n = ptr;
              wdat_n  = bus.wdata[2:0];
              ptr_n   = ptr + PTR_ONE;
              if (bus.wdata[15:4] != 12'd0) state_n = S_FILL;
            end
            default: ;
          endcase
        end
      end
      S_UNPACK: begin
        wen_n   = 1'b1;
        waddr_n = ptr;
        wdat_n  = texel_at(texels, idx);
        ptr_n   = ptr + PTR_ONE;
        idx_n   = idx + 3'd1;
        if (idx == 3'd7) state_n = S_IDLE;
      end
      S_FILL: begin
        wen_n   = 1'b1;
        waddr_n = ptr;
        wdat_n  = color;
        ptr_n   = ptr + PTR_ONE;
        rem_n   = rem - 12'd1;
        if (rem == 12'd1) state_n = S_IDLE;
      end
      default: state_n = S_IDLE;
    endcase
  end

  // Control and output registers; reset aborts any operation in flight.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      state    <= S_IDLE;
      ptr      <= '0;
      idx      <= 3'd0;
      rem      <= 12'd0;
      ready_q  <= 1'b0;
      rdata_q  <= 32'd0;
      tm_wen   <= 1'b0;
      tm_waddr <= '0;
      tm_wdata <= 3'd0;
    end else begin
      state    <= state_n;
      ptr      <= ptr_n;
      idx      <= idx_n;
      rem      <= rem_n;
      ready_q  <= ready_n;
      rdata_q  <= rdata_n;
      tm_wen   <= wen_n;
      tm_waddr <= waddr_n;
      tm_wdata <= wdat_n;
    end
  end

  // Operand holding registers, only meaningful while an operation runs.
  always_ff @(posedge clk) begin
    texels <= texels_n;
    color  <= color_n;
  end

endmodule

// File: tb/tb_texture_writer.sv
// Scoreboard bench for texture_writer: expected texel writes are queued when
// a DATA/FILL write is issued and popped as tm_wen pulses appear.
module tb_texture_writer;
  localparam int ADDR_W = 12;

  logic              clk = 1'b0;
  logic              resetn = 1'b0;
  logic              tm_wen;
  logic [ADDR_W-1:0] tm_waddr;
  logic [2:0]        tm_wdata;

  texture_writer_if bus();

  texture_writer #(.ADDR_W(ADDR_W)) dut (
    .clk      (clk),
    .resetn   (resetn),
    .bus      (bus),
    .tm_wen   (tm_wen),
    .tm_waddr (tm_waddr),
    .tm_wdata (tm_wdata)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [ADDR_W-1:0] a;
    logic [2:0]        d;
  } exp_t;

  exp_t              sb[$];
  int                n_tests = 0;
  int                n_fail  = 0;
  int                run_len = 0;
  int                max_run = 0;
  logic [ADDR_W-1:0] mptr = '0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=0x%08h expected=0x%08h", tag, got, exp);
    end
  endtask

  // Monitor: every memory write must match the head of the scoreboard.
  always @(negedge clk) begin
    if (tm_wen === 1'b1) begin
      run_len++;
      if (run_len > max_run) max_run = run_len;
      if (sb.size() == 0) begin
        check("unexpected_wen", 32'(tm_waddr), 32'hFFFF_FFFF);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check("tm_waddr", 32'(tm_waddr), 32'(e.a));
        check("tm_wdata", 32'(tm_wdata), 32'(e.d));
      end
    end else begin
      run_len = 0;
    end
  end

  function automatic void push_data(input logic [31:0] d);
    for (int i = 0; i < 8; i++) begin
      exp_t e;
      e.a = mptr;
      e.d = 3'((d >> (3 * i)) & 32'h7);
      sb.push_back(e);
      mptr = mptr + 1'b1;
    end
  endfunction

  function automatic void push_fill(input logic [2:0] c, input int cnt);
    for (int i = 0; i < cnt; i++) begin
      exp_t e;
      e.a = mptr;
      e.d = c;
      sb.push_back(e);
      mptr = mptr + 1'b1;
    end
  endfunction

  // Caller is at a negedge; returns one idle negedge after the acknowledge.
  task automatic bus_wr(input logic [1:0] r, input logic [31:0] d);
    int n;
    bus.valid = 1'b1;
    bus.wstrb = 4'hF;
    bus.addr  = {r, 2'b00};
    bus.wdata = d;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (bus.ready !== 1'b1 && n < 6000);
    if (n >= 6000) check("wr_timeout", 32'(n), 32'd0);
    bus.valid = 1'b0;
    bus.wstrb = 4'h0;
    @(negedge clk);
  endtask

  task automatic bus_rd(input logic [1:0] r, output logic [31:0] d, output int n);
    bus.valid = 1'b1;
    bus.wstrb = 4'h0;
    bus.addr  = {r, 2'b00};
    bus.wdata = 32'd0;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (bus.ready !== 1'b1 && n < 100);
    if (n >= 100) check("rd_timeout", 32'(n), 32'd0);
    d = bus.rdata;
    bus.valid = 1'b0;
    @(negedge clk);
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (sb.size() != 0 && n < 6000) begin
      @(negedge clk);
      n++;
    end
    check("drain", 32'(sb.size()), 32'd0);
    @(negedge clk);
  endtask

  initial begin
    logic [31:0] rd;
    int          lat;
    int          wen_cnt;

    bus.valid = 1'b0;
    bus.wstrb = 4'h0;
    bus.addr  = 4'h0;
    bus.wdata = 32'd0;

    // Reset state
    repeat (3) @(negedge clk);
    check("rst_wen", 32'(tm_wen), 32'd0);
    check("rst_waddr", 32'(tm_waddr), 32'd0);
    check("rst_wdata", 32'(tm_wdata), 32'd0);
    check("rst_ready", 32'(bus.ready), 32'd0);
    check("rst_rdata", bus.rdata, 32'd0);
    resetn = 1'b1;
    @(negedge clk);
    bus_rd(2'd3, rd, lat);
    check("rst_status", rd, 32'h0000_0000);
    wen_cnt = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (tm_wen !== 1'b0) wen_cnt++;
    end
    check("idle_wen_cnt", 32'(wen_cnt), 32'd0);

    // Basic unpack
    bus_wr(2'd0, 32'h0000_0010);
    mptr = 12'h010;
    bus_rd(2'd0, rd, lat);
    check("ptr_read", rd, 32'h0000_0010);
    push_data(32'h00FA_C688);
    bus_wr(2'd1, 32'h00FA_C688);
    drain();
    bus_rd(2'd3, rd, lat);
    check("status_after_data", rd, 32'h0000_0018);

    // Unpack across the wrap point
    bus_wr(2'd0, 32'h0000_0FFC);
    mptr = 12'hFFC;
    push_data(32'hFF12_3456);
    bus_wr(2'd1, 32'hFF12_3456);
    drain();
    bus_rd(2'd3, rd, lat);
    check("status_after_wrap", rd, 32'h0000_0004);

    // Fill of 32 texels
    bus_wr(2'd0, 32'h0000_0100);
    mptr = 12'h100;
    push_fill(3'd5, 32);
    bus_wr(2'd2, 32'h0000_01F5);
    drain();
    bus_rd(2'd3, rd, lat);
    check("status_after_fill", rd, 32'h0000_0120);

    // Single-texel fill
    push_fill(3'd2, 1);
    bus_wr(2'd2, 32'h0000_0002);
    drain();
    bus_rd(2'd0, rd, lat);
    check("ptr_after_fill1", rd, 32'h0000_0121);

    // Full-memory fill leaves the pointer where it was
    push_fill(3'd3, 4096);
    bus_wr(2'd2, 32'h0000_FFF3);
    drain();
    bus_rd(2'd3, rd, lat);
    check("status_after_fill4096", rd, 32'h0000_0121);

    // Back-to-back DATA writes with a STATUS poll in between
    bus_wr(2'd0, 32'h0000_0040);
    mptr = 12'h040;
    max_run = 0;
    push_data(32'h0012_3456);
    push_data(32'h0076_5432);
    bus_wr(2'd1, 32'h0012_3456);
    bus_rd(2'd3, rd, lat);
    check("busy_read_lat", 32'(lat), 32'd1);
    check("busy_bit", 32'(rd[31]), 32'd1);
    check("busy_ptr_nonzero", 32'(rd[11:0] > 12'h040), 32'd1);
    bus_wr(2'd1, 32'h0076_5432);
    drain();
    check("contiguous_run", 32'(max_run), 32'd16);
    bus_rd(2'd3, rd, lat);
    check("status_after_b2b", rd, 32'h0000_0050);

    // Reset in the third cycle of a 100-texel fill
    bus_wr(2'd0, 32'h0000_0200);
    mptr = 12'h200;
    push_fill(3'd6, 3);
    bus_wr(2'd2, 32'h0000_0636);
    @(negedge clk);
    #1 resetn = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_mid_wen", 32'(tm_wen), 32'd0);
    check("rst_mid_sb", 32'(sb.size()), 32'd0);
    resetn = 1'b1;
    @(negedge clk);
    bus_rd(2'd3, rd, lat);
    check("status_after_rst", rd, 32'h0000_0000);
    mptr = 12'h000;
    push_data(32'h00AB_CDEF);
    bus_wr(2'd1, 32'h00AB_CDEF);
    drain();
    bus_rd(2'd0, rd, lat);
    check("ptr_after_rst_data", rd, 32'h0000_0008);
    repeat (5) @(negedge clk);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/texture_writer.md
# texture_writer

CPU-side write controller for the 4096 x 3-bit texture memory in the video subsystem. It sits on the picosoc peripheral bus and drives the texture memory write port. It unpacks 32-bit bus writes into eight 3-bit texels written on consecutive cycles, and runs a hardware fill engine for clearing or painting texel ranges. It owns an auto-incrementing write pointer, so firmware can stream tile data without re-addressing.

## Interface
- ADDR_W, 12: texture memory address width; the pointer wraps modulo 2^ADDR_W.
- clk  in  1  system clock. It also clocks the texture memory write port.
- resetn  in  1  synchronous, active-low reset.
- valid  in  1  bus request, held until ready.
- wstrb  in  4  nonzero = write, zero = read.
- addr  in  4  register select; addr[3:2] used.
- wdata  in  32  write data.
- ready  out  1  one-cycle registered acknowledge.
- rdata  out  32  read data, valid when ready=1.
- tm_wen  out  1  texture memory write enable.
- tm_waddr  out  ADDR_W  texture memory write address.
- tm_wdata  out  3  texel value.

## Operation
- Registers, selected by addr[3:2]:
  - 0 PTR: a write sets ptr = wdata[11:0]. A read returns {20'b0, ptr}.
  - 1 DATA: a write starts UNPACK of texels wdata[2:0], [5:3], … [23:21]. Texel i goes to ptr+i, and ptr advances by 8. wdata[31:24] is ignored. A read returns 0.
  - 2 FILL: a write starts FILL of color wdata[2:0] over count = wdata[15:4]+1 texels (1..4096) from ptr, and ptr advances by count. A read returns 0.
  - 3 STATUS: a read returns {busy, 3'b0, 16'b0, ptr}, with busy in bit 31. A write is acknowledged and has no effect.
- FSM states:
  - IDLE: accepts requests.
  - UNPACK: a 3-bit texel index counts 0..7.
  - FILL: a 12-bit remaining counter.
- Acceptance:
  - In IDLE, a request with valid=1 and ready=0 is accepted, and ready is pulsed next cycle.
  - Writes to DATA or FILL move to UNPACK or FILL.
  - Writes to PTR or STATUS and all reads complete immediately.
- While busy (not IDLE):
  - All writes stall: ready stays 0 and valid must stay held.
  - Reads are accepted, with a one-cycle ready pulse.
- UNPACK:
  - Each cycle drives tm_wen=1, tm_waddr=ptr, tm_wdata=texel[idx], then ptr+1 and idx+1.
  - After idx=7 the FSM returns to IDLE.
- FILL:
  - Each cycle drives tm_wen=1, tm_waddr=ptr, tm_wdata=color, then ptr+1 and remaining−1.
  - After the last texel the FSM returns to IDLE.
- Address arithmetic:
  - All pointer arithmetic is ADDR_W-bit unsigned and wraps 4095→0 silently.
  - A FILL of 4096 rewrites the whole memory and leaves ptr unchanged.
- A stalled write is accepted in the first cycle the state is IDLE, so there are no idle cycles between back-to-back DATA writes beyond the acceptance cycle.
- busy = (state != IDLE).

## Timing
- Reset: when resetn=0 at a clk edge, the following take effect at that edge:
  - state=IDLE, ptr=0.
  - ready=0, rdata=0.
  - tm_wen=0, tm_waddr=0, tm_wdata=0.
- Reset mid-UNPACK or mid-FILL aborts the operation. Texels already written stay in memory, and no further tm_wen pulses occur.
- Acknowledge: a request sampled at edge E0 gets ready=1 after E0 (visible during cycle E0..E1). ready is low after E1, even if valid stays high.
- UNPACK/FILL write timing:
  - The first tm_wen is high in the same cycle as ready, i.e. registered at E0 with the first address.
  - UNPACK holds tm_wen for exactly 8 consecutive cycles. FILL holds it for exactly count cycles.
  - tm_waddr, tm_wdata and tm_wen are all registered outputs.
- busy:
  - STATUS busy reads 1 from the cycle after acceptance through the last write cycle.
  - The next write is accepted at the edge ending the last write cycle.
- Per texel: memory throughput is 1 texel/clk. A DATA write costs 8 clk of occupancy.
- tm_wen is never high in IDLE, except in the final cycle of an operation.

## Test plan
- Reset then STATUS read → rdata=0x00000000. tm_wen stays 0 for 20 cycles.
- PTR=0x010, then DATA=0x00FAC688 → 8 consecutive tm_wen cycles, addresses 0x010..0x017, texels 0,1,2,3,4,5,6,7. STATUS afterwards shows ptr=0x018, busy=0.
- PTR=0xFFC, DATA=0x00FAC688 → addresses 0xFFC,0xFFD,0xFFE,0xFFF,0x000..0x003. Final ptr=0x004.
- PTR=0x100, FILL with color 5 and count field 0x01F → exactly 32 writes of value 5 to 0x100..0x11F. Final ptr=0x120.
- Back-to-back DATA writes and a STATUS read issued mid-UNPACK:
  - The read returns busy=1 within 1 cycle.
  - The second write's ready is delayed until the first completes.
  - 16 contiguous texel writes occur.
- resetn=0 asserted on the 3rd cycle of a FILL of count 100 → tm_wen low from that edge onward, and ptr=0. A subsequent DATA write starts at address 0.
